// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop, LSB first.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIN  = 2'b10
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic               accept_s;
    logic               finish_s;

    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               c_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   res_r;

    logic [WIDTH-1:0]   b_in_s;
    logic               c_in_s;
    logic [1:0]         fa_s;
    logic               sum_bit_s;
    logic               carry_s;
    logic [WIDTH-1:0]   res_shift_s;

    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   sum_r;
    logic               cout_r;
    logic               ovf_r;

    // Single full-adder cell, returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        full_add = {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
    endfunction

`ifdef SERIAL_ADDER_SUB_EN
    // Subtract is A + ~B + 1, so the carry flop doubles as the +1.
    always_comb begin
        b_in_s = b;
        c_in_s = cin;
        if (sub) begin
            b_in_s = ~b;
            c_in_s = 1'b1;
        end else begin
            b_in_s = b;
            c_in_s = cin;
        end
    end
`else
    logic unused_sub_s;
    assign b_in_s       = b;
    assign c_in_s       = cin;
    assign unused_sub_s = sub;
`endif

    assign fa_s        = full_add(a_r[0], b_r[0], c_r);
    assign sum_bit_s   = fa_s[0];
    assign carry_s     = fa_s[1];
    assign res_shift_s = {sum_bit_s, res_r[WIDTH-1:1]};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode with accept and completion strobes.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        finish_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s  = RUN;
                    accept_s = 1'b1;
                end else begin
                    state_s  = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == LAST_BIT) begin
                    state_s  = FIN;
                    finish_s = 1'b1;
                end else begin
                    state_s  = RUN;
                end
            end
            FIN: begin
                if (start) begin
                    state_s  = RUN;
                    accept_s = 1'b1;
                end else begin
                    state_s  = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Operand shift registers, carry flop, bit counter and partial result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r   <= {WIDTH{1'b0}};
            b_r   <= {WIDTH{1'b0}};
            c_r   <= 1'b0;
            cnt_r <= {CNT_W{1'b0}};
            res_r <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            a_r   <= a;
            b_r   <= b_in_s;
            c_r   <= c_in_s;
            cnt_r <= {CNT_W{1'b0}};
            res_r <= {WIDTH{1'b0}};
        end else if (state_r == RUN) begin
            a_r   <= {1'b0, a_r[WIDTH-1:1]};
            b_r   <= {1'b0, b_r[WIDTH-1:1]};
            c_r   <= carry_s;
            cnt_r <= cnt_r + CNT_W'(1);
            res_r <= res_shift_s;
        end
    end

    // Published result: only the completion edge may touch SUM/COUT/OVF.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            sum_r  <= {WIDTH{1'b0}};
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            busy_r <= (state_s == RUN);
            done_r <= finish_s;
            if (finish_s) begin
                sum_r  <= res_shift_s;
                cout_r <= carry_s;
                ovf_r  <= c_r ^ carry_s;
            end
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;
    assign ovf  = ovf_r;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder against an arithmetic reference model.
// Honours SERIAL_ADDER_SUB_EN the same way as the design.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_checks;
    int n_pass;

    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sub   (sub),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {ovf, cout, sum} from plain word arithmetic and the signed-overflow rule.
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mcin, input logic msub);
        logic [W-1:0] bb;
        logic         cc;
        logic [W:0]   full;
        logic         mo;
        bb = mb;
        cc = mcin;
`ifdef SERIAL_ADDER_SUB_EN
        if (msub) begin
            bb = ~mb;
            cc = 1'b1;
        end
`else
        if (msub) begin
            bb = mb;
        end
`endif
        full = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, cc};
        mo = (ma[W-1] == bb[W-1]) && (full[W-1] != ma[W-1]);
        model = {mo, full[W], full[W-1:0]};
    endfunction

    // Starts one operation at the current negedge and checks every cycle up to the FIN cycle.
    task automatic run_op(input string name, input logic [W-1:0] oa, input logic [W-1:0] ob,
                          input logic ocin, input logic osub, input int pulse_at);
        logic [W+1:0] m;
        m = model(oa, ob, ocin, osub);
        start = 1'b1;
        a = oa;
        b = ob;
        cin = ocin;
        sub = osub;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < W; i++) begin
            n_checks++;
            if (busy !== 1'b1) $display("FAIL %s busy cyc%0d: got %b want 1", name, i, busy);
            else n_pass++;
            n_checks++;
            if (done !== 1'b0) $display("FAIL %s done cyc%0d: got %b want 0", name, i, done);
            else n_pass++;
            n_checks++;
            if ({ovf, cout, sum} !== {exp_ovf, exp_cout, exp_sum})
                $display("FAIL %s hold cyc%0d: got ovf=%b cout=%b sum=%h want ovf=%b cout=%b sum=%h",
                         name, i, ovf, cout, sum, exp_ovf, exp_cout, exp_sum);
            else n_pass++;
            if (i == pulse_at) begin
                start = 1'b1;
                a = 8'h01;
                b = 8'h01;
                cin = 1'b0;
                sub = 1'b0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0)
            $display("FAIL %s fin: got done=%b busy=%b want done=1 busy=0", name, done, busy);
        else n_pass++;
        n_checks++;
        if (sum !== m[W-1:0]) $display("FAIL %s sum: got %h want %h", name, sum, m[W-1:0]);
        else n_pass++;
        n_checks++;
        if (cout !== m[W]) $display("FAIL %s cout: got %b want %b", name, cout, m[W]);
        else n_pass++;
        n_checks++;
        if (ovf !== m[W+1]) $display("FAIL %s ovf: got %b want %b", name, ovf, m[W+1]);
        else n_pass++;
        exp_sum  = m[W-1:0];
        exp_cout = m[W];
        exp_ovf  = m[W+1];
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a = 8'h00;
        b = 8'h00;
        cin = 1'b0;
        sub = 1'b0;
        exp_sum = 8'h00;
        exp_cout = 1'b0;
        exp_ovf = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, ovf, cout, sum} !== {4'b0000, 8'h00})
            $display("FAIL reset: got busy=%b done=%b ovf=%b cout=%b sum=%h want all 0",
                     busy, done, ovf, cout, sum);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_idle_gap();
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL idle: got done=%b busy=%b want 0 0", done, busy);
        else n_pass++;
        n_checks++;
        if (sum !== exp_sum) $display("FAIL idle sum: got %h want %h", sum, exp_sum);
        else n_pass++;
    endtask

    task automatic test_vectors();
        run_op("add35_4a", 8'h35, 8'h4A, 1'b0, 1'b0, -1);
        test_idle_gap();
        run_op("addff_01", 8'hFF, 8'h01, 1'b0, 1'b0, -1);
        test_idle_gap();
        run_op("add7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, -1);
        test_idle_gap();
        run_op("sub10_20", 8'h10, 8'h20, 1'b0, 1'b1, -1);
        test_idle_gap();
        run_op("sub80_01", 8'h80, 8'h01, 1'b1, 1'b1, -1);
        test_idle_gap();
    endtask

    task automatic test_start_ignored();
        run_op("mid_pulse", 8'h35, 8'h4A, 1'b1, 1'b0, 2);
        test_idle_gap();
        run_op("late_pulse", 8'hC3, 8'h5A, 1'b0, 1'b0, W - 1);
        test_idle_gap();
    endtask

    task automatic test_back_to_back();
        run_op("b2b_0", 8'h12, 8'h34, 1'b0, 1'b0, -1);
        run_op("b2b_1", 8'h80, 8'h80, 1'b1, 1'b0, -1);
        run_op("b2b_2", 8'h55, 8'hAA, 1'b1, 1'b1, -1);
        test_idle_gap();
    endtask

    task automatic test_reset_mid_run();
        start = 1'b1;
        a = 8'hAA;
        b = 8'h55;
        cin = 1'b0;
        sub = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, ovf, cout, sum} !== {4'b0000, 8'h00})
            $display("FAIL midrun_reset: got busy=%b done=%b ovf=%b cout=%b sum=%h want all 0",
                     busy, done, ovf, cout, sum);
        else n_pass++;
        exp_sum = 8'h00;
        exp_cout = 1'b0;
        exp_ovf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("post_reset", 8'h01, 8'h02, 1'b1, 1'b0, -1);
        test_idle_gap();
    endtask

    task automatic test_random();
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        for (int k = 0; k < 24; k++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            run_op("rand", ra, rb, 1'($urandom), 1'($urandom),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W - 1)) : -1);
            if ($urandom_range(0, 1) == 1) begin
                test_idle_gap();
            end
        end
        test_idle_gap();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_pass = 0;
        test_reset();
        test_vectors();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
